// File: rtl/run_sequencer_if.sv
// Handshake and strobe bundle between the bench/decoder side and the run sequencer.
interface run_sequencer_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned CW = 16
) ();
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          halt;
    logic          rd_mem;
    logic          wr_mem_req;
    logic          reg_write_req;
    logic          pc_init;
    logic          pc_en;
    logic          sc_clr;
    logic          reg_write;
    logic          mem_write;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output req, prog_ctr, halt, rd_mem, wr_mem_req, reg_write_req,
        input  pc_init, pc_en, sc_clr, reg_write, mem_write, busy, done, timeout, cycle_cnt
    );

    modport slave (
        input  req, prog_ctr, halt, rd_mem, wr_mem_req, reg_write_req,
        output pc_init, pc_en, sc_clr, reg_write, mem_write, busy, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the accumulator core: req/done handshake, PC/shift-carry init,
// load stalls, write gating and run termination (halt, end PC, cycle budget).
module run_sequencer #(
    parameter int unsigned D         = 12,
    parameter int unsigned END_PC    = 128,
    parameter int unsigned LOAD_WAIT = 1,
    parameter int unsigned CW        = 16,
    parameter int unsigned MAX_CYC   = 4000
) (
    input logic           clk,
    input logic           reset,
    run_sequencer_if.slave bus
);
    localparam int unsigned    SW          = 3;
    localparam logic [D-1:0]   END_PC_W    = D'(END_PC);
    localparam logic [CW-1:0]  BUDGET_LAST = CW'(MAX_CYC - 1);
    localparam bit             BUDGET_EN   = (MAX_CYC != 0);
    localparam bit             LOAD_STALLS = (LOAD_WAIT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_STALL,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic [CW-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic           timeout_q, timeout_d;

    logic           pc_init_c, pc_en_c, sc_clr_c, reg_write_c, mem_write_c, busy_c, done_c;
    logic [CW-1:0]  cycle_inc;
    logic           budget_last;
    logic           run_end;

    // Cycle counter saturates instead of wrapping.
    assign cycle_inc   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CW'(1);
    assign budget_last = BUDGET_EN && (cycle_cnt_q == BUDGET_LAST);
    assign run_end     = bus.halt || (bus.prog_ctr == END_PC_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            stall_q     <= '0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next state and enables; only the store/reg-write strobes pass straight through.
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        cycle_cnt_d = cycle_cnt_q;
        timeout_d   = timeout_q;
        pc_init_c   = 1'b0;
        pc_en_c     = 1'b0;
        sc_clr_c    = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) state_d = S_INIT;
            end

            S_INIT: begin
                pc_init_c   = 1'b1;
                sc_clr_c    = 1'b1;
                busy_c      = 1'b1;
                cycle_cnt_d = '0;
                timeout_d   = 1'b0;
                state_d     = S_RUN;
            end

            S_RUN: begin
                busy_c      = 1'b1;
                cycle_cnt_d = cycle_inc;
                if (run_end) begin
                    state_d = S_DONE;
                end else if (budget_last) begin
                    // The last budgeted instruction still executes normally.
                    pc_en_c     = 1'b1;
                    reg_write_c = bus.reg_write_req;
                    mem_write_c = bus.wr_mem_req;
                    timeout_d   = 1'b1;
                    state_d     = S_DONE;
                end else if (LOAD_STALLS && bus.rd_mem) begin
                    stall_d = SW'(LOAD_WAIT);
                    state_d = S_STALL;
                end else begin
                    pc_en_c     = 1'b1;
                    reg_write_c = bus.reg_write_req;
                    mem_write_c = bus.wr_mem_req;
                end
            end

            S_STALL: begin
                busy_c      = 1'b1;
                cycle_cnt_d = cycle_inc;
                stall_d     = stall_q - SW'(1);
                if (budget_last) begin
                    stall_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else if (stall_q == SW'(1)) begin
                    // Load data is valid now: commit the register write and advance.
                    pc_en_c     = 1'b1;
                    reg_write_c = bus.reg_write_req;
                    state_d     = S_RUN;
                end
            end

            S_DONE: begin
                done_c = 1'b1;
                if (!bus.req) state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pc_init   = pc_init_c;
    assign bus.pc_en     = pc_en_c;
    assign bus.sc_clr    = sc_clr_c;
    assign bus.reg_write = reg_write_c;
    assign bus.mem_write = mem_write_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: instance A (LOAD_WAIT=2, long budget), instance B (LOAD_WAIT=1, MAX_CYC=10),
// each checked every cycle against a behavioural run model, plus literal end-of-run expectations.
module tb_run_sequencer;
    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_LOAD = 3;
    localparam int P_DONE = 4;
    localparam int END_PC = 128;

    typedef struct packed {
        int phase;
        int el;
        int cyc;
        bit tmo;
    } mst_t;

    logic clk;
    logic reset;

    run_sequencer_if #(.D(12), .CW(16)) bus_a ();
    run_sequencer_if #(.D(12), .CW(16)) bus_b ();

    run_sequencer #(.D(12), .END_PC(128), .LOAD_WAIT(2), .CW(16), .MAX_CYC(4000)) u_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    run_sequencer #(.D(12), .END_PC(128), .LOAD_WAIT(1), .CW(16), .MAX_CYC(10)) u_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    int   checks   = 0;
    int   failures = 0;
    mst_t m_a, m_b;
    bit [6:0] exp_a, exp_b, act_a, act_b;
    int   xcyc_a, xcyc_b;
    bit   xtmo_a, xtmo_b;
    int   env_pc_a = 0, env_pc_b = 0;
    int   hpc_a = -1, lpc_a = -1, hpc_b = -1, lpc_b = -1;
    int   pcen_cnt_a = 0, init_cnt_a = 0;
    int   tr_n = 0;
    bit [2:0] tr_pcen, tr_rw, tr_mw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Run rules: one init cycle, then one instruction per cycle, loads hold the PC for lw extra
    // cycles, run ends on halt/end PC or when the cycle budget is used up.
    function automatic bit [6:0] model_step(input int lw, input int maxc, input bit rq,
                                            input bit h, input bit rd, input bit wm, input bit rw,
                                            input int pc, inout mst_t m);
        bit pi = 1'b0, pe = 1'b0, sc = 1'b0, rwo = 1'b0, mwo = 1'b0, bz = 1'b0, dn = 1'b0;
        bit last;
        int nxt;
        last = (maxc != 0) && (m.cyc == maxc - 1);
        nxt  = (m.cyc >= 65535) ? 65535 : m.cyc + 1;
        case (m.phase)
            P_IDLE: if (rq) m.phase = P_INIT;
            P_INIT: begin
                pi = 1'b1; sc = 1'b1; bz = 1'b1;
                m.cyc = 0; m.tmo = 1'b0; m.phase = P_RUN;
            end
            P_RUN: begin
                bz = 1'b1; m.cyc = nxt;
                if (h || pc == END_PC) m.phase = P_DONE;
                else if (last) begin
                    pe = 1'b1; rwo = rw; mwo = wm; m.tmo = 1'b1; m.phase = P_DONE;
                end else if (rd && lw > 0) begin
                    m.el = 1; m.phase = P_LOAD;
                end else begin
                    pe = 1'b1; rwo = rw; mwo = wm;
                end
            end
            P_LOAD: begin
                bz = 1'b1; m.cyc = nxt;
                if (last) begin
                    m.tmo = 1'b1; m.phase = P_DONE;
                end else if (m.el == lw) begin
                    pe = 1'b1; rwo = rw; m.phase = P_RUN;
                end else m.el = m.el + 1;
            end
            default: begin
                dn = 1'b1;
                if (!rq) m.phase = P_IDLE;
            end
        endcase
        return {pi, pe, sc, rwo, mwo, bz, dn};
    endfunction

    // Toy program: odd PCs write a register, PC%4==2 stores; the load PC asserts both strobes.
    task automatic apply();
        bus_a.prog_ctr      = 12'(env_pc_a);
        bus_a.halt          = (env_pc_a == hpc_a);
        bus_a.rd_mem        = (env_pc_a == lpc_a);
        bus_a.reg_write_req = (env_pc_a % 2 == 1) || (env_pc_a == lpc_a);
        bus_a.wr_mem_req    = (env_pc_a % 4 == 2) || (env_pc_a == lpc_a);
        bus_b.prog_ctr      = 12'(env_pc_b);
        bus_b.halt          = (env_pc_b == hpc_b);
        bus_b.rd_mem        = (env_pc_b == lpc_b);
        bus_b.reg_write_req = (env_pc_b % 2 == 1) || (env_pc_b == lpc_b);
        bus_b.wr_mem_req    = (env_pc_b % 4 == 2) || (env_pc_b == lpc_b);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic wait_done(input bit on_b, input int budget, input string nm);
        int n = 0;
        #1;
        while (!(on_b ? bus_b.done : bus_a.done) && n < budget) begin
            cyc();
            #1;
            n++;
        end
        check(nm, int'(on_b ? bus_b.done : bus_a.done), 1);
    endtask

    // Per-cycle compare against the model; also plays the PC block from the expected enables.
    always @(negedge clk) begin
        if (!reset) begin
            m_a = '0; m_b = '0;
            exp_a = '0; exp_b = '0;
            xcyc_a = 0; xcyc_b = 0; xtmo_a = 1'b0; xtmo_b = 1'b0;
        end else begin
            xcyc_a = m_a.cyc; xtmo_a = m_a.tmo;
            xcyc_b = m_b.cyc; xtmo_b = m_b.tmo;
            exp_a = model_step(2, 4000, bus_a.req, bus_a.halt, bus_a.rd_mem, bus_a.wr_mem_req,
                               bus_a.reg_write_req, int'(bus_a.prog_ctr), m_a);
            exp_b = model_step(1, 10, bus_b.req, bus_b.halt, bus_b.rd_mem, bus_b.wr_mem_req,
                               bus_b.reg_write_req, int'(bus_b.prog_ctr), m_b);
            if (exp_a[5]) pcen_cnt_a++;
            if (exp_a[6]) init_cnt_a++;
            if (exp_a[1] && int'(bus_a.prog_ctr) == 5 && tr_n < 8) begin
                tr_pcen = {tr_pcen[1:0], bus_a.pc_en};
                tr_rw   = {tr_rw[1:0], bus_a.reg_write};
                tr_mw   = {tr_mw[1:0], bus_a.mem_write};
                tr_n++;
            end
            env_pc_a = exp_a[6] ? 0 : (exp_a[5] ? env_pc_a + 1 : env_pc_a);
            env_pc_b = exp_b[6] ? 0 : (exp_b[5] ? env_pc_b + 1 : env_pc_b);
        end
        act_a = {bus_a.pc_init, bus_a.pc_en, bus_a.sc_clr, bus_a.reg_write, bus_a.mem_write,
                 bus_a.busy, bus_a.done};
        act_b = {bus_b.pc_init, bus_b.pc_en, bus_b.sc_clr, bus_b.reg_write, bus_b.mem_write,
                 bus_b.busy, bus_b.done};
        check("a_enables", int'(act_a), int'(exp_a));
        check("a_cycle_cnt", int'(bus_a.cycle_cnt), xcyc_a);
        check("a_timeout", int'(bus_a.timeout), int'(xtmo_a));
        check("b_enables", int'(act_b), int'(exp_b));
        check("b_cycle_cnt", int'(bus_b.cycle_cnt), xcyc_b);
        check("b_timeout", int'(bus_b.timeout), int'(xtmo_b));
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        apply();
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        check("reset_busy", int'(bus_a.busy), 0);
        check("reset_cycle_cnt", int'(bus_a.cycle_cnt), 0);

        // Basic run to the end PC, no loads.
        pcen_cnt_a = 0; init_cnt_a = 0;
        cyc(); bus_a.req = 1'b1;
        wait_done(1'b0, 300, "t2_done");
        check("t2_cycle_cnt", int'(bus_a.cycle_cnt), 129);
        check("t2_timeout", int'(bus_a.timeout), 0);
        check("t2_model_pcen_cycles", pcen_cnt_a, 128);
        check("t2_model_init_cycles", init_cnt_a, 1);
        check("t2_model_cycles", m_a.cyc, 129);
        repeat (3) cyc();
        #1 check("t6_hold_done", int'(bus_a.done), 1);
        bus_a.req = 1'b0;
        cyc(); cyc();
        #1 check("t6_idle_done", int'(bus_a.done), 0);

        // Load at PC 5 with two wait cycles.
        lpc_a = 5; tr_n = 0; tr_pcen = '0; tr_rw = '0; tr_mw = '0;
        cyc(); bus_a.req = 1'b1;
        wait_done(1'b0, 300, "t3_done");
        check("t3_cycle_cnt", int'(bus_a.cycle_cnt), 131);
        check("t3_pc5_cycles", tr_n, 3);
        check("t3_pc_en_trace", int'(tr_pcen), 1);
        check("t3_reg_write_trace", int'(tr_rw), 1);
        check("t3_mem_write_trace", int'(tr_mw), 0);
        bus_a.req = 1'b0;
        cyc(); cyc();

        // Asynchronous reset mid-run with req still high.
        bus_a.req = 1'b1;
        repeat (20) cyc();
        reset = 1'b0;
        #1;
        check("t1_busy", int'(bus_a.busy), 0);
        check("t1_done", int'(bus_a.done), 0);
        check("t1_pc_en", int'(bus_a.pc_en), 0);
        check("t1_cycle_cnt", int'(bus_a.cycle_cnt), 0);
        cyc();
        reset = 1'b1;
        wait_done(1'b0, 300, "t1_rerun_done");
        check("t1_rerun_cycle_cnt", int'(bus_a.cycle_cnt), 131);
        bus_a.req = 1'b0;
        cyc(); cyc();

        // Halt and load on the same instruction: halt wins.
        hpc_a = 10; lpc_a = 10;
        cyc(); bus_a.req = 1'b1;
        wait_done(1'b0, 300, "t4_done");
        check("t4_cycle_cnt", int'(bus_a.cycle_cnt), 11);
        check("t4_timeout", int'(bus_a.timeout), 0);
        bus_a.req = 1'b0;
        cyc(); cyc();

        // Budget of 10 cycles on instance B.
        cyc(); bus_b.req = 1'b1;
        wait_done(1'b1, 100, "t5_done");
        check("t5_cycle_cnt", int'(bus_b.cycle_cnt), 10);
        check("t5_timeout", int'(bus_b.timeout), 1);
        repeat (3) cyc();
        #1 check("t5_hold_done", int'(bus_b.done), 1);
        bus_b.req = 1'b0;
        cyc(); cyc();
        #1 check("t5_idle_done", int'(bus_b.done), 0);
        check("t5_idle_timeout_kept", int'(bus_b.timeout), 1);

        // Budget runs out while a load is stalled.
        lpc_b = 8;
        cyc(); bus_b.req = 1'b1;
        wait_done(1'b1, 100, "t5b_done");
        check("t5b_cycle_cnt", int'(bus_b.cycle_cnt), 10);
        check("t5b_timeout", int'(bus_b.timeout), 1);

        // Re-arm after a timeout: INIT clears the timeout flag.
        bus_b.req = 1'b0;
        cyc(); cyc();
        bus_b.req = 1'b1;
        cyc(); cyc();
        #1;
        check("t6_timeout_cleared", int'(bus_b.timeout), 0);
        check("t6_busy", int'(bus_b.busy), 1);
        wait_done(1'b1, 100, "t6_done");
        check("t6_timeout_again", int'(bus_b.timeout), 1);
        bus_b.req = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
